// File: rtl/message_scheduler.sv
// SHA-256 message schedule generator: loads a 16-word block, then streams
// W[0..63] through a valid/ready output register using a 16-word circular buffer.

// sigma1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
module sigma1_func (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);
  assign o_y = {i_x[16:0], i_x[31:17]} ^ {i_x[18:0], i_x[31:19]} ^ (i_x >> 10);
endmodule

// state | meaning
// IDLE  | waiting for start; no handshakes accepted or offered
// LOAD  | accepting message words M[0..15] into the buffer
// GEN   | one settle cycle, then producing W[0..63] into the output register
// DONE  | one-cycle done pulse, then back to IDLE
module message_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        w_valid,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  input  logic        w_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GEN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_buf [16];
  logic [4:0]  r_i;
  logic [6:0]  r_t;
  logic        r_prime;
  logic        r_w_valid;
  logic [31:0] r_w_data;
  logic [5:0]  r_w_idx;

  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_load;
  logic [3:0]  w_t4;
  logic [3:0]  w_idx_m2;
  logic [3:0]  w_idx_m7;
  logic [3:0]  w_idx_m15;
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_sum;
  logic [31:0] w_sched;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  assign w_valid = r_w_valid;
  assign w_data  = r_w_data;
  assign w_idx   = r_w_idx;

  assign w_in_hs  = (r_state == S_LOAD) && in_valid;
  assign w_out_hs = r_w_valid && w_ready;
  // r_prime holds off the first load by one cycle after entering GEN
  assign w_load   = (r_state == S_GEN) && r_prime && (!r_w_valid || w_ready) && !r_t[6];

  assign w_t4      = r_t[3:0];
  assign w_idx_m2  = w_t4 - 4'd2;
  assign w_idx_m7  = w_t4 - 4'd7;
  assign w_idx_m15 = w_t4 - 4'd15;

  sigma1_func u_sigma1 (
    .i_x (r_buf[w_idx_m2]),
    .o_y (w_s1)
  );

  assign w_s0    = sigma0(r_buf[w_idx_m15]);
  // (t-16)&15 equals t&15, so the oldest term sits in the slot about to be overwritten
  assign w_sum   = w_s1 + r_buf[w_idx_m7] + w_s0 + r_buf[w_t4];
  assign w_sched = (r_t[6:4] == 3'd0) ? r_buf[w_t4] : w_sum;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_i == 5'd15)) w_state_nxt = S_GEN;
      end
      S_GEN: begin
        if (w_out_hs && (r_w_idx == 6'd63) && r_t[6]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters, message buffer and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) r_buf[k] <= 32'd0;
      r_i       <= 5'd0;
      r_t       <= 7'd0;
      r_prime   <= 1'b0;
      r_w_valid <= 1'b0;
      r_w_data  <= 32'd0;
      r_w_idx   <= 6'd0;
    end else begin
      r_prime <= (r_state == S_GEN);
      if ((r_state == S_IDLE) && start) begin
        r_i <= 5'd0;
        r_t <= 7'd0;
      end
      if (w_in_hs) begin
        r_buf[r_i[3:0]] <= in_data;
        r_i             <= r_i + 5'd1;
      end
      if (w_load) begin
        r_w_data  <= w_sched;
        r_w_idx   <= r_t[5:0];
        r_w_valid <= 1'b1;
        r_t       <= r_t + 7'd1;
        if (r_t[6:4] != 3'd0) r_buf[w_t4] <= w_sched;
      end else if (w_out_hs) begin
        r_w_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_message_scheduler.sv
// Bench for message_scheduler: a reference SHA-256 schedule model fills an
// expectation queue per block; output handshakes pop and compare.
`timescale 1ns/1ps
module tb_message_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        w_valid;
  logic [31:0] w_data;
  logic [5:0]  w_idx;
  logic        w_ready;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tb_m [16];
  logic [31:0] tb_w [64];
  logic [37:0] exp_q [$];

  message_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_idx    (w_idx),
    .w_ready  (w_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule on a flat 64-entry array
  task automatic push_expected();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) tb_w[t] = tb_m[t];
      else tb_w[t] = (rotr(tb_w[t-2], 17) ^ rotr(tb_w[t-2], 19) ^ (tb_w[t-2] >> 10))
                     + tb_w[t-7]
                     + (rotr(tb_w[t-15], 7) ^ rotr(tb_w[t-15], 18) ^ (tb_w[t-15] >> 3))
                     + tb_w[t-16];
      exp_q.push_back({t[5:0], tb_w[t]});
    end
  endtask

  task automatic set_abc();
    for (int k = 0; k < 16; k++) tb_m[k] = 32'd0;
    tb_m[0]  = 32'h61626380;
    tb_m[15] = 32'h00000018;
  endtask

  // Pulse start, then feed the 16 words; valid every gap-th cycle.
  // Returns one time unit after the edge of the 16th handshake.
  task automatic load_block(input int gap, input bit spam_start);
    int k = 0;
    int cyc = 0;
    bit hs;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < 16 && cyc < 200) begin
      in_valid = ((cyc % gap) == 0);
      in_data  = tb_m[k];
      if (spam_start) start = cyc[0];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    n_tests++;
    if (k != 16) begin
      n_fail++;
      $display("FAIL load_handshakes: got %0d words, required 16", k);
    end
  endtask

  // Consume the block; bp=1 toggles w_ready randomly; spam=1 pokes start/in_valid.
  task automatic drain_block(input string name, input bit bp, input bit spam);
    logic [37:0] e;
    bit          prev_stall = 0;
    bit          seen = 0;
    logic [31:0] prev_data = 0;
    logic [5:0]  prev_idx = 0;
    int          cyc = 0;
    int          gaps = 0;
    int          stall_bad = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      if (prev_stall && (w_data !== prev_data || w_idx !== prev_idx)) stall_bad++;
      if (seen && !w_valid) gaps++;
      w_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (spam) begin
        start    = cyc[0];
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      if (w_valid) seen = 1;
      if (w_valid && w_ready) begin
        e = exp_q.pop_front();
        n_tests++;
        if (w_data !== e[31:0] || w_idx !== e[37:32]) begin
          n_fail++;
          $display("FAIL %s_word: idx %0d data %08h, required idx %0d data %08h",
                   name, w_idx, w_data, e[37:32], e[31:0]);
        end
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      prev_idx   = w_idx;
      @(posedge clk); #1;
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    w_ready  = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_tests++;
    if (stall_bad != 0) begin
      n_fail++;
      $display("FAIL %s_stall_hold: %0d changes while stalled, required 0", name, stall_bad);
    end
    if (!bp) begin
      n_tests++;
      if (gaps != 0) begin
        n_fail++;
        $display("FAIL %s_throughput: %0d bubble cycles, required 0", name, gaps);
      end
    end
    n_tests++;
    if (done !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done %b w_valid %b busy %b, required 1 0 1", name, done, w_valid, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: done %b busy %b in_ready %b, required 0 0 0", name, done, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0; w_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({w_valid, w_data, w_idx, in_ready, busy, done} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_state: v %b d %08h i %0d ir %b b %b dn %b, required all 0",
               w_valid, w_data, w_idx, in_ready, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    logic [31:0] chk [6];
    set_abc();
    push_expected();
    chk = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h600003C6};
    // Guard the model itself against the published "abc" schedule words
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (tb_w[(k < 2) ? k * 15 : k + 14] !== chk[k]) begin
        n_fail++;
        $display("FAIL abc_model_w%0d: got %08h, required %08h", (k < 2) ? k * 15 : k + 14,
                 tb_w[(k < 2) ? k * 15 : k + 14], chk[k]);
      end
    end
    load_block(1, 0);
    drain_block("abc", 0, 0);
  endtask

  task automatic test_zero();
    for (int k = 0; k < 16; k++) tb_m[k] = 32'd0;
    push_expected();
    load_block(1, 0);
    drain_block("zero", 0, 0);
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 16; k++) tb_m[k] = $urandom;
      push_expected();
      load_block(1, 0);
      drain_block("bp", 1, 0);
    end
  endtask

  task automatic test_reset_mid_gen();
    int cyc = 0;
    set_abc();
    load_block(1, 0);
    w_ready = 1'b1;
    while (!(w_valid && w_idx == 6'd20) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (!(w_valid && w_idx == 6'd20)) begin
      n_fail++;
      $display("FAIL rstgen_reach20: w_valid %b idx %0d, required 1 20", w_valid, w_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    w_ready = 1'b0;
    n_tests++;
    if (w_valid !== 1'b0 || busy !== 1'b0 || w_idx !== 6'd0 || w_data !== 32'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstgen_state: v %b b %b idx %0d d %08h dn %b, required 0 0 0 0 0",
               w_valid, busy, w_idx, w_data, done);
    end
    push_expected();
    load_block(1, 0);
    drain_block("rstgen_abc", 0, 0);
  endtask

  task automatic test_start_ignored();
    set_abc();
    push_expected();
    load_block(1, 1);
    drain_block("spam_abc", 0, 1);
  endtask

  task automatic test_in_valid_gaps();
    for (int k = 0; k < 16; k++) tb_m[k] = $urandom;
    push_expected();
    load_block(3, 0);
    w_ready = 1'b1;
    n_tests++;
    if (w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_latency_e0: w_valid %b, required 0", w_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_latency_e1: w_valid %b, required 0", w_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (w_valid !== 1'b1 || w_idx !== 6'd0) begin
      n_fail++;
      $display("FAIL gaps_latency_e2: w_valid %b idx %0d, required 1 0", w_valid, w_idx);
    end
    drain_block("gaps", 0, 0);
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_backpressure();
    test_reset_mid_gen();
    test_start_ignored();
    test_in_valid_gaps();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
